packet_scheduler: RTL and testbench

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/packet_scheduler.sv | 112 +++++++++++
 tb/tb_packet_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_scheduler.sv
// packet_scheduler: data-island packet arbiter; strict-priority requester 0
// with a consecutive-grant cap, round-robin among the remaining requesters.
module packet_scheduler #(
  parameter int                 NUM_REQ        = 4,
  parameter logic [NUM_REQ-1:0] INFOFRAME_MASK = 4'b1100,
  parameter int                 MAX_CONSEC     = 4
) (
  input  logic               clk_pixel,
  input  logic               reset_n,
  input  logic               data_island_period,
  input  logic               frame_pulse,
  input  logic [NUM_REQ-1:0] req,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic [NUM_REQ-1:0] ack,
  output logic [4:0]         counter
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] CAP  = 4'(MAX_CONSEC);
  localparam logic [2:0] LAST = 3'(NUM_REQ - 1);

  state_t             state;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] clr;
  logic [NUM_REQ-1:0] eff;
  logic [2:0]         ptr;
  logic [2:0]         ptr_nx;
  logic [2:0]         arb_sel;
  logic [3:0]         consec;
  logic [3:0]         consec_nx;
  logic               done;
  logic               arb_valid;
  logic               found;
  logic               cap_hit;

  // Completion bookkeeping, visible to the arbiter in the same cycle
  always_comb begin
    done = data_island_period && counter == 5'd31 && sel_valid;
    clr  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      clr[i] = done && sel == 3'(i);
    ptr_nx    = ptr;
    consec_nx = consec;
    if (done) begin
      if (sel == 3'd0) begin
        consec_nx = (consec >= CAP) ? CAP : consec + 4'd1;
      end else begin
        consec_nx = '0;
        ptr_nx    = (sel == LAST) ? 3'd1 : sel + 3'd1;
      end
    end
  end

  always_comb begin
    eff       = req | (pending & ~clr);
    cap_hit   = consec_nx == CAP && |eff[NUM_REQ-1:1];
    arb_valid = |eff;
    arb_sel   = '0;
    found     = 1'b0;
    if (!eff[0] || cap_hit) begin
      // two passes: pointer..N-1, then 1..pointer-1
      for (int i = 1; i < NUM_REQ; i++)
        if (!found && eff[i] && 3'(i) >= ptr_nx) begin
          arb_sel = 3'(i);
          found   = 1'b1;
        end
      for (int i = 1; i < NUM_REQ; i++)
        if (!found && eff[i]) begin
          arb_sel = 3'(i);
          found   = 1'b1;
        end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      ack       <= '0;
      counter   <= '0;
      pending   <= '0;
      ptr       <= 3'd1;
      consec    <= '0;
    end else begin
      ack     <= clr;
      pending <= (pending & ~clr)
               | (frame_pulse ? INFOFRAME_MASK : '0);
      ptr     <= ptr_nx;
      consec  <= consec_nx;
      unique case (state)
        IDLE:    if (data_island_period) state <= SEND;
        SEND:    if (!data_island_period) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (data_island_period) begin
        counter <= counter + 5'd1;
        if (counter == 5'd31) begin
          sel       <= arb_sel;
          sel_valid <= arb_valid;
        end
      end else begin
        counter   <= '0;
        sel       <= arb_sel;
        sel_valid <= arb_valid;
      end
    end
  end

endmodule

// File: tb/tb_packet_scheduler.sv
// tb_packet_scheduler: directed scenarios plus random traffic, checked
// every cycle against a queue-free arithmetic model of the scheduler.
module tb_packet_scheduler;

  localparam int N    = 4;
  localparam int MAXC = 4;
  localparam logic [3:0] MASK = 4'b1100;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic       dip;
  logic       frame_pulse;
  logic [3:0] req;
  logic [2:0] sel;
  logic       sel_valid;
  logic [3:0] ack;
  logic [4:0] counter;

  int checks = 0;
  int errors = 0;
  int ack_code = 0;

  logic [3:0] m_pend;
  logic [3:0] m_ack;
  logic       m_valid;
  int         m_sel;
  int         m_ptr;
  int         m_consec;
  int         m_cnt;

  packet_scheduler #(
    .NUM_REQ(N),
    .INFOFRAME_MASK(MASK),
    .MAX_CONSEC(MAXC)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .data_island_period(dip),
    .frame_pulse(frame_pulse),
    .req(req),
    .sel(sel),
    .sel_valid(sel_valid),
    .ack(ack),
    .counter(counter)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend   = '0;
    m_ack    = '0;
    m_valid  = 1'b0;
    m_sel    = 0;
    m_ptr    = 1;
    m_consec = 0;
    m_cnt    = 0;
  endtask

  task automatic pick(input logic [3:0] eff, output int s, output logic v);
    int c;
    s = 0;
    v = (eff != 0);
    if (eff == 0) return;
    if (eff[0] && !(m_consec == MAXC && eff[3:1] != 0)) return;
    for (int k = 0; k < N - 1; k++) begin
      c = 1 + (m_ptr - 1 + k) % (N - 1);
      if (eff[c[1:0]]) begin
        s = c;
        return;
      end
    end
  endtask

  task automatic model_step();
    logic [3:0] np;
    logic       done;
    int         s;
    logic       v;
    if (!reset_n) begin
      model_reset();
      return;
    end
    np    = m_pend;
    m_ack = '0;
    done  = dip && m_cnt == 31 && m_valid;
    if (done) begin
      m_ack = 4'(1 << m_sel);
      np    = np & ~m_ack;
      if (m_sel == 0) begin
        m_consec = (m_consec < MAXC) ? m_consec + 1 : MAXC;
      end else begin
        m_consec = 0;
        m_ptr    = (m_sel % (N - 1)) + 1;
      end
    end
    if (!dip || m_cnt == 31) begin
      pick(req | np, s, v);
      m_sel   = s;
      m_valid = v;
    end
    m_cnt = dip ? (m_cnt + 1) % 32 : 0;
    if (frame_pulse) np = np | MASK;
    m_pend = np;
  endtask

  task automatic check_all();
    chk("sel", int'(sel), m_sel);
    chk("sel_valid", int'(sel_valid), int'(m_valid));
    chk("ack", int'(ack), int'(m_ack));
    chk("counter", int'(counter), m_cnt);
    for (int i = 0; i < N; i++)
      if (ack[i]) ack_code = ack_code * 16 + i + 1;
  endtask

  task automatic cycle();
    @(posedge clk_pixel);
    model_step();
    @(negedge clk_pixel);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dip = 1'b0;
    frame_pulse = 1'b0;
    req = '0;
    run(2);
    reset_n = 1'b1;
    ack_code = 0;
  endtask

  int left;

  initial begin
    reset_n = 1'b0;
    dip = 1'b0;
    frame_pulse = 1'b0;
    req = '0;
    model_reset();
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_valid", int'(sel_valid), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_counter", int'(counter), 0);
    @(negedge clk_pixel);
    do_reset();

    // single streaming requester, two back-to-back packets
    req = 4'b0001;
    run(2);
    dip = 1'b1;
    run(64);
    dip = 1'b0;
    run(2);
    chk("s031_acks", ack_code, 'h11);

    // requester 0 capped after four grants, infoframe 2 slips in
    do_reset();
    req = 4'b0001;
    frame_pulse = 1'b1;
    cycle();
    frame_pulse = 1'b0;
    run(2);
    dip = 1'b1;
    run(6 * 32);
    dip = 1'b0;
    run(1);
    chk("s032_acks", ack_code, 'h111131);

    // nothing requested: null packet, no ack
    do_reset();
    run(2);
    dip = 1'b1;
    run(32);
    dip = 1'b0;
    run(1);
    chk("s033_acks", ack_code, 0);
    chk("s033_valid", int'(sel_valid), 0);

    // round-robin alternation
    do_reset();
    req = 4'b0110;
    run(2);
    dip = 1'b1;
    run(4 * 32);
    dip = 1'b0;
    run(1);
    chk("s034_acks", ack_code, 'h2323);

    // island abort keeps the infoframe pending
    do_reset();
    frame_pulse = 1'b1;
    cycle();
    frame_pulse = 1'b0;
    run(2);
    dip = 1'b1;
    run(17);
    dip = 1'b0;
    run(2);
    chk("s035_abort", ack_code, 0);
    dip = 1'b1;
    run(32);
    dip = 1'b0;
    run(1);
    chk("s035_resend", ack_code, 'h3);

    // reset mid-packet
    do_reset();
    req = 4'b0001;
    run(2);
    dip = 1'b1;
    run(9);
    chk("s036_cnt9", int'(counter), 9);
    #1 reset_n = 1'b0;
    #1;
    chk("s036_sel", int'(sel), 0);
    chk("s036_valid", int'(sel_valid), 0);
    chk("s036_ack", int'(ack), 0);
    chk("s036_counter", int'(counter), 0);
    model_reset();
    dip = 1'b0;
    req = '0;
    cycle();
    reset_n = 1'b1;
    ack_code = 0;
    run(40);
    chk("s036_noack", ack_code, 0);

    // random traffic with aborts, frame pulses and stray resets
    do_reset();
    left = 0;
    for (int n = 0; n < 6000; n++) begin
      if (left == 0) begin
        if (dip) begin
          dip  = 1'b0;
          left = $urandom_range(1, 4);
        end else begin
          dip  = 1'b1;
          left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 63)
                                             : 32 * $urandom_range(1, 4);
        end
      end
      left--;
      if ($urandom_range(0, 7) == 0) begin
        req = 4'($urandom);
        if ($urandom_range(0, 3) != 0) req[0] = 1'b1;
      end
      frame_pulse = ($urandom_range(0, 60) == 0);
      reset_n = ($urandom_range(0, 700) != 0);
      cycle();
    end
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
